// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, frame length, device commands.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RX      = 3'd1,
    ST_INHIBIT = 3'd2,
    ST_REQ     = 3'd3,
    ST_TX      = 3'd4,
    ST_ACK     = 3'd5
  } ps2_state_e;

  // Parity bit that makes the 9-bit group {parity, data} contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive byte FIFO, first-word-fall-through. A push into a full FIFO is dropped
// and flagged, unless a pop frees the slot in the same cycle.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;

  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_valid    = (r_count != '0);
  assign w_pop      = i_pop && o_valid;
  assign w_wr       = i_push && (!w_full || w_pop);
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign o_overflow = r_overflow;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && w_full && !w_pop;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host: receives device frames into a FIFO and sends command bytes.
// All PS/2 activity is sampled on a divided clock-enable tick.
//
//   state      | meaning
//   IDLE       | lines released, waiting for a start bit or a transmit request
//   RX         | shifting in device frame, one bit per PS2_CLK falling edge
//   INHIBIT    | host holds PS2_CLK low before a transmit
//   REQ        | host holds PS2_DAT low (start) and PS2_CLK low for one tick
//   TX         | host drives D0..D7, parity on device falling edges, then stop
//   ACK        | waiting for the device acknowledge edge
import ps2_pkg::*;

module ps2_host_fifo #(
  parameter int CLK_DIV_LOG2  = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int INHIBIT_TICKS = 24,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic       iCLK_50,
  input  logic       iRST_n,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic [7:0] iTX_DATA,
  input  logic       iTX_VALID,
  output logic       oTX_READY,
  output logic       oTX_DONE,
  output logic       oTX_ACK_ERR,
  output logic [7:0] oRX_DATA,
  output logic       oRX_VALID,
  input  logic       iRX_READY,
  output logic       oPARITY_ERR,
  output logic       oFRAME_ERR,
  output logic       oOVERFLOW
);

  localparam int TMR_MAX = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_TICKS - 1);

  ps2_state_e              r_state;
  logic [CLK_DIV_LOG2-1:0] r_div_cnt;
  logic                    r_tick_d;
  logic [2:0]              r_clk_sync;
  logic [1:0]              r_dat_sync;
  logic [TW-1:0]           r_timer;
  logic [3:0]              r_bit_cnt;
  logic [9:0]              r_rx_shift;
  logic [8:0]              r_tx_shift;
  logic                    r_rx_done;
  logic                    r_clk_oe;
  logic                    r_dat_oe;
  logic                    r_ready_en;
  logic                    r_tx_done;
  logic                    r_ack_err;
  logic                    r_parity_err;
  logic                    r_frame_err;
  logic                    w_tick;
  logic                    w_fall;
  logic                    w_dat;
  logic                    w_par_ok;
  logic                    w_push;

  assign PS2_CLK = r_clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = r_dat_oe ? 1'b0 : 1'bz;

  assign w_tick   = (r_div_cnt == '0);
  // Synchronisers move on a tick, so the edge is visible exactly one cycle later.
  assign w_fall   = r_tick_d && r_clk_sync[2] && !r_clk_sync[1];
  assign w_dat    = r_dat_sync[1];
  assign w_par_ok = ^r_rx_shift[8:0];
  assign w_push   = (r_state == ST_RX) && r_rx_done && r_rx_shift[9] && w_par_ok;

  // A start bit wins over a same-cycle transmit request, so ready drops then.
  assign oTX_READY   = r_ready_en && (r_state == ST_IDLE) && !w_fall;
  assign oTX_DONE    = r_tx_done;
  assign oTX_ACK_ERR = r_ack_err;
  assign oPARITY_ERR = r_parity_err;
  assign oFRAME_ERR  = r_frame_err;

  // Sample-rate tick divider and two-stage line synchronisers with edge history.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      r_div_cnt  <= '1;
      r_tick_d   <= 1'b0;
      r_clk_sync <= 3'b111;
      r_dat_sync <= 2'b11;
    end else begin
      r_div_cnt <= r_div_cnt - 1'b1;
      r_tick_d  <= w_tick;
      if (w_tick) begin
        r_clk_sync <= {r_clk_sync[1:0], PS2_CLK};
        r_dat_sync <= {r_dat_sync[0], PS2_DAT};
      end
    end
  end

  // Protocol sequencer: frame reception, host transmit, timeouts and status pulses.
  always_ff @(posedge iCLK_50 or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_tx_shift   <= '0;
      r_rx_done    <= 1'b0;
      r_clk_oe     <= 1'b0;
      r_dat_oe     <= 1'b0;
      r_ready_en   <= 1'b0;
      r_tx_done    <= 1'b0;
      r_ack_err    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_ready_en   <= 1'b1;
      r_tx_done    <= 1'b0;
      r_ack_err    <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_rx_done <= 1'b0;
          if (w_fall) begin
            if (!w_dat) begin
              r_state   <= ST_RX;
              r_bit_cnt <= 4'd1;
              r_timer   <= TMO_LOAD;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else if (iTX_VALID && oTX_READY) begin
            r_tx_shift <= {odd_parity(iTX_DATA), iTX_DATA};
            r_timer    <= INH_LOAD;
            r_clk_oe   <= 1'b1;
            r_state    <= ST_INHIBIT;
          end
        end
        ST_RX: begin
          if (r_rx_done) begin
            r_rx_done <= 1'b0;
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
            if (!r_rx_shift[9])  r_frame_err  <= 1'b1;
            else if (!w_par_ok)  r_parity_err <= 1'b1;
          end else if (w_fall) begin
            r_rx_shift <= {w_dat, r_rx_shift[9:1]};
            r_bit_cnt  <= r_bit_cnt + 1'b1;
            r_timer    <= TMO_LOAD;
            if (r_bit_cnt == 4'(FRAME_BITS - 1)) r_rx_done <= 1'b1;
          end else if (w_tick) begin
            if (r_timer == '0) begin
              r_frame_err <= 1'b1;
              r_bit_cnt   <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        ST_INHIBIT: begin
          if (w_tick) begin
            if (r_timer == '0) begin
              r_dat_oe <= 1'b1;
              r_state  <= ST_REQ;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (w_tick) begin
            r_clk_oe  <= 1'b0;
            r_timer   <= TMO_LOAD;
            r_bit_cnt <= '0;
            r_state   <= ST_TX;
          end
        end
        ST_TX, ST_ACK: begin
          if (w_fall) begin
            r_timer <= TMO_LOAD;
            if (r_state == ST_ACK) begin
              r_tx_done <= 1'b1;
              r_ack_err <= w_dat;
              r_bit_cnt <= '0;
              r_state   <= ST_IDLE;
            end else if (r_bit_cnt == 4'd9) begin
              r_dat_oe <= 1'b0;
              r_state  <= ST_ACK;
            end else begin
              r_dat_oe   <= !r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[8:1]};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
          end else if (w_tick) begin
            if (r_timer == '0) begin
              r_frame_err <= 1'b1;
              r_tx_done   <= 1'b1;
              r_ack_err   <= 1'b1;
              r_clk_oe    <= 1'b0;
              r_dat_oe    <= 1'b0;
              r_bit_cnt   <= '0;
              r_state     <= ST_IDLE;
            end else begin
              r_timer <= r_timer - 1'b1;
            end
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  ps2_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk      (iCLK_50),
    .i_rst_n    (iRST_n),
    .i_push     (w_push),
    .i_data     (r_rx_shift[7:0]),
    .i_pop      (iRX_READY),
    .o_data     (oRX_DATA),
    .o_valid    (oRX_VALID),
    .o_overflow (oOVERFLOW)
  );

endmodule
